// File: rtl/frog_pkg.sv
// frog_pkg: shared grid constants, coordinate type, game-state and key-direction enums.
package frog_pkg;

  localparam int GRID_N = 16;

  typedef logic [3:0] coord_t;

  localparam coord_t COORD_MAX = 4'(GRID_N - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    HIT       = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/frog_controller_key_edge.sv
// key_edge: rising-edge move request for one key; with KEY_REPEAT_EN defined it also
// issues a repeat request every REPEAT_CYC cycles while the key stays held and enabled.
module key_edge #(
  parameter int REPEAT_CYC = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  input  logic enable,
  output logic step
);

  logic prev_r;
  logic edge_s;

  assign edge_s = key & ~prev_r;

  // Previous key level, tracked in every game state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= key;
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int CW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  logic [CW-1:0] cnt_r;
  logic          rep_s;

  assign rep_s = enable & key & ~edge_s & (cnt_r == REPEAT_LAST);
  assign step  = edge_s | rep_s;

  // Hold counter restarts on every issued move, on release and outside PLAY.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (!enable || !key || edge_s || rep_s) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end
`else
  logic unused_s;

  assign step     = edge_s;
  assign unused_s = enable ^ (REPEAT_CYC == 0);
`endif

endmodule

// File: rtl/frog_controller.sv
// frog_controller: frog position, lives, score and IDLE/PLAY/HIT/GAME_OVER control.
// Optional build macro: KEY_REPEAT_EN (held-key auto-repeat inside key_edge).
module frog_controller
  import frog_pkg::*;
#(
  parameter coord_t     START_ROW   = 4'd15,
  parameter coord_t     START_COL   = 4'd7,
  parameter logic [2:0] LIVES       = 3'd3,
  parameter int         RESPAWN_CYC = 25,
  parameter int         REPEAT_CYC  = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       crash_in,
  output logic [3:0] frog_row,
  output logic [3:0] frog_col,
  output logic [2:0] lives,
  output logic [7:0] score,
  output logic       game_over,
  output logic       respawning
);

  localparam int TW = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(RESPAWN_CYC - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  state_t        state_r;
  state_t        state_next_s;
  coord_t        row_r;
  coord_t        row_next_s;
  coord_t        col_r;
  coord_t        col_next_s;
  logic [2:0]    lives_r;
  logic [2:0]    lives_next_s;
  logic [7:0]    score_r;
  logic [7:0]    score_next_s;
  logic [TW-1:0] timer_r;
  logic [TW-1:0] timer_next_s;
  logic          game_over_r;
  logic          respawning_r;
  logic          play_s;
  logic [3:0]    key_s;
  logic [3:0]    step_s;

  assign play_s = (state_r == PLAY);
  assign key_s  = {key_right, key_left, key_down, key_up};

  for (genvar k = 0; k < 4; k++) begin : g_key
    key_edge #(
      .REPEAT_CYC(REPEAT_CYC)
    ) u_key_edge (
      .clk    (clk),
      .reset_n(reset_n),
      .key    (key_s[k]),
      .enable (play_s),
      .step   (step_s[k])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; the last life lost goes straight to GAME_OVER.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = PLAY;
        else       state_next_s = IDLE;
      end
      PLAY: begin
        if (crash_in) begin
          if (lives_r <= 3'd1) state_next_s = GAME_OVER;
          else                 state_next_s = HIT;
        end else begin
          state_next_s = PLAY;
        end
      end
      HIT: begin
        if (timer_r == {TW{1'b0}}) state_next_s = PLAY;
        else                       state_next_s = HIT;
      end
      GAME_OVER: begin
        if (start) state_next_s = PLAY;
        else       state_next_s = GAME_OVER;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Position, lives, score and respawn timer; a crash overrides any move that cycle.
  always_comb begin
    row_next_s   = row_r;
    col_next_s   = col_r;
    lives_next_s = lives_r;
    score_next_s = score_r;
    timer_next_s = timer_r;
    case (state_r)
      IDLE, GAME_OVER: begin
        row_next_s = START_ROW;
        col_next_s = START_COL;
        if (start) begin
          lives_next_s = LIVES;
          score_next_s = 8'd0;
        end else begin
          lives_next_s = lives_r;
          score_next_s = score_r;
        end
      end
      PLAY: begin
        if (crash_in) begin
          lives_next_s = lives_r - 3'd1;
          row_next_s   = START_ROW;
          col_next_s   = START_COL;
          timer_next_s = TIMER_LOAD;
        end else if (step_s[DIR_UP]) begin
          if (row_r == 4'd1) begin
            row_next_s   = START_ROW;
            col_next_s   = START_COL;
            score_next_s = sat_inc8(score_r);
          end else if (row_r != 4'd0) begin
            row_next_s = row_r - 4'd1;
          end else begin
            row_next_s = row_r;
          end
        end else if (step_s[DIR_DOWN]) begin
          if (row_r != COORD_MAX) row_next_s = row_r + 4'd1;
          else                    row_next_s = row_r;
        end else if (step_s[DIR_LEFT]) begin
          if (col_r != 4'd0) col_next_s = col_r - 4'd1;
          else               col_next_s = col_r;
        end else if (step_s[DIR_RIGHT]) begin
          if (col_r != COORD_MAX) col_next_s = col_r + 4'd1;
          else                    col_next_s = col_r;
        end else begin
          row_next_s = row_r;
          col_next_s = col_r;
        end
      end
      HIT: begin
        if (timer_r != {TW{1'b0}}) timer_next_s = timer_r - TIMER_ONE;
        else                       timer_next_s = timer_r;
      end
      default: begin
        row_next_s = START_ROW;
        col_next_s = START_COL;
      end
    endcase
  end

  // Datapath and status-flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      row_r        <= START_ROW;
      col_r        <= START_COL;
      lives_r      <= LIVES;
      score_r      <= 8'd0;
      timer_r      <= {TW{1'b0}};
      game_over_r  <= 1'b0;
      respawning_r <= 1'b0;
    end else begin
      row_r        <= row_next_s;
      col_r        <= col_next_s;
      lives_r      <= lives_next_s;
      score_r      <= score_next_s;
      timer_r      <= timer_next_s;
      game_over_r  <= (state_next_s == GAME_OVER);
      respawning_r <= (state_next_s == HIT);
    end
  end

  assign frog_row   = row_r;
  assign frog_col   = col_r;
  assign lives      = lives_r;
  assign score      = score_r;
  assign game_over  = game_over_r;
  assign respawning = respawning_r;

endmodule

// File: tb/tb_frog_controller.sv
// tb_frog_controller: directed scenarios plus randomized play against a behavioural game model.
module tb_frog_controller;

  localparam int RESPAWN = 25;
  localparam int REPEAT  = 4;
  localparam int M_IDLE  = 0;
  localparam int M_PLAY  = 1;
  localparam int M_HIT   = 2;
  localparam int M_OVER  = 3;
  localparam logic [3:0] K_NONE  = 4'b0000;
  localparam logic [3:0] K_UP    = 4'b0001;
  localparam logic [3:0] K_DOWN  = 4'b0010;
  localparam logic [3:0] K_LEFT  = 4'b0100;
  localparam logic [3:0] K_RIGHT = 4'b1000;

  logic       clk = 1'b0;
  logic       reset_n, start, key_up, key_down, key_left, key_right, crash_in;
  logic [3:0] frog_row, frog_col;
  logic [2:0] lives;
  logic [7:0] score;
  logic       game_over, respawning;

  int checks = 0;
  int errors = 0;

  int         m_mode, m_row, m_col, m_lives, m_score, m_hit;
  logic [3:0] m_prev;
`ifdef KEY_REPEAT_EN
  int         m_held [4];
`endif

  frog_controller #(
    .RESPAWN_CYC(RESPAWN),
    .REPEAT_CYC (REPEAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .crash_in  (crash_in),
    .frog_row  (frog_row),
    .frog_col  (frog_col),
    .lives     (lives),
    .score     (score),
    .game_over (game_over),
    .respawning(respawning)
  );

  always #5 clk = ~clk;

  // Game rules: first requested direction in up/down/left/right order; crash beats moves.
  task automatic model_step(input logic [3:0] keys, input logic crash, input logic st);
    int req, dr, dc, nr, nc;
    bit fire;
    req = -1;
    for (int k = 0; k < 4; k++) begin
      fire = keys[k] && !m_prev[k];
`ifdef KEY_REPEAT_EN
      if (m_mode == M_PLAY && keys[k] && !fire) begin
        m_held[k]++;
        if (m_held[k] == REPEAT) begin
          fire = 1'b1;
          m_held[k] = 0;
        end
      end else begin
        m_held[k] = 0;
      end
`endif
      m_prev[k] = keys[k];
      if (fire && req < 0) req = k;
    end
    case (m_mode)
      M_IDLE: if (st) begin m_mode = M_PLAY; m_lives = 3; m_score = 0; end
      M_PLAY: begin
        if (crash) begin
          m_lives--;
          m_row = 15;
          m_col = 7;
          m_hit = RESPAWN;
          m_mode = (m_lives == 0) ? M_OVER : M_HIT;
        end else if (req >= 0) begin
          dr = (req == 0) ? -1 : (req == 1) ? 1 : 0;
          dc = (req == 2) ? -1 : (req == 3) ? 1 : 0;
          nr = m_row + dr;
          nc = m_col + dc;
          if (nr >= 0 && nr < 16 && nc >= 0 && nc < 16) begin
            if (nr == 0) begin
              m_score = (m_score < 255) ? m_score + 1 : 255;
              m_row = 15;
              m_col = 7;
            end else begin
              m_row = nr;
              m_col = nc;
            end
          end
        end
      end
      M_HIT: begin
        m_hit--;
        if (m_hit == 0) m_mode = M_PLAY;
      end
      default: if (st) begin m_mode = M_PLAY; m_lives = 3; m_score = 0; end
    endcase
  endtask

  task automatic tick(input logic [3:0] keys, input logic crash, input logic st);
    reset_n = 1'b1;
    {key_right, key_left, key_down, key_up} = keys;
    crash_in = crash;
    start = st;
    @(posedge clk);
    model_step(keys, crash, st);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    {key_right, key_left, key_down, key_up} = K_NONE;
    crash_in = 1'b0;
    start = 1'b0;
    @(posedge clk);
    m_mode = M_IDLE; m_row = 15; m_col = 7; m_lives = 3; m_score = 0; m_hit = 0;
    m_prev = 4'b0000;
`ifdef KEY_REPEAT_EN
    for (int k = 0; k < 4; k++) m_held[k] = 0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (frog_row !== 4'd15) begin errors++; $display("FAIL reset_row got %0d want 15", frog_row); end
    if (frog_col !== 4'd7) begin errors++; $display("FAIL reset_col got %0d want 7", frog_col); end
    if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", lives); end
    if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
    if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over got %b want 0", game_over); end
    if (respawning !== 1'b0) begin errors++; $display("FAIL reset_respawning got %b want 0", respawning); end
  endtask

  task automatic test_reset_mid_play();
    tick(K_NONE, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin tick(K_UP, 1'b0, 1'b0); tick(K_NONE, 1'b0, 1'b0); end
    checks++;
    if (frog_row !== 4'd4) begin errors++; $display("FAIL midplay_row got %0d want 4", frog_row); end
    do_reset();
    checks += 4;
    if (frog_row !== 4'd15) begin errors++; $display("FAIL midreset_row got %0d want 15", frog_row); end
    if (frog_col !== 4'd7) begin errors++; $display("FAIL midreset_col got %0d want 7", frog_col); end
    if (lives !== 3'd3) begin errors++; $display("FAIL midreset_lives got %0d want 3", lives); end
    if (score !== 8'd0) begin errors++; $display("FAIL midreset_score got %0d want 0", score); end
    tick(K_UP, 1'b0, 1'b0);
    tick(K_NONE, 1'b0, 1'b0);
    checks++;
    if (frog_row !== 4'd15) begin errors++; $display("FAIL idle_key_ignored row got %0d want 15", frog_row); end
  endtask

  task automatic test_edge_moves();
    int exp;
    tick(K_NONE, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(K_UP, 1'b0, 1'b0);
    tick(K_NONE, 1'b0, 1'b0);
    checks++;
    if (frog_row !== 4'd14) begin errors++; $display("FAIL held_up_once row got %0d want 14", frog_row); end
    for (int i = 1; i <= 8; i++) begin
      tick(K_LEFT, 1'b0, 1'b0);
      tick(K_NONE, 1'b0, 1'b0);
      exp = (7 - i < 0) ? 0 : 7 - i;
      checks++;
      if (frog_col !== exp[3:0]) begin errors++; $display("FAIL left_press%0d col got %0d want %0d", i, frog_col, exp); end
    end
  endtask

  task automatic test_goal();
    int exp;
    for (int i = 0; i < 13; i++) begin tick(K_UP, 1'b0, 1'b0); tick(K_NONE, 1'b0, 1'b0); end
    checks++;
    if (frog_row !== 4'd1) begin errors++; $display("FAIL pre_goal_row got %0d want 1", frog_row); end
    tick(K_UP, 1'b0, 1'b0);
    checks += 3;
    if (frog_row !== 4'd15) begin errors++; $display("FAIL goal_row got %0d want 15", frog_row); end
    if (frog_col !== 4'd7) begin errors++; $display("FAIL goal_col got %0d want 7", frog_col); end
    if (score !== 8'd1) begin errors++; $display("FAIL goal_score got %0d want 1", score); end
    tick(K_NONE, 1'b0, 1'b0);
    for (int g = 2; g <= 256; g++) begin
      for (int i = 0; i < 15; i++) begin tick(K_UP, 1'b0, 1'b0); tick(K_NONE, 1'b0, 1'b0); end
      exp = (g > 255) ? 255 : g;
      checks++;
      if (score !== exp[7:0]) begin errors++; $display("FAIL goal_sat goal%0d score got %0d want %0d", g, score, exp); end
    end
  endtask

  task automatic test_crash();
    tick(K_RIGHT, 1'b0, 1'b0);
    tick(K_NONE, 1'b0, 1'b0);
    tick(K_UP, 1'b0, 1'b0);
    tick(K_NONE, 1'b0, 1'b0);
    tick(K_RIGHT, 1'b1, 1'b0);
    checks += 5;
    if (lives !== 3'd2) begin errors++; $display("FAIL crash_lives got %0d want 2", lives); end
    if (frog_row !== 4'd15) begin errors++; $display("FAIL crash_row got %0d want 15", frog_row); end
    if (frog_col !== 4'd7) begin errors++; $display("FAIL crash_col got %0d want 7", frog_col); end
    if (score !== 8'd255) begin errors++; $display("FAIL crash_score got %0d want 255", score); end
    if (respawning !== 1'b1) begin errors++; $display("FAIL crash_respawning got %b want 1", respawning); end
    for (int i = 1; i <= RESPAWN; i++) begin
      tick((i % 2 == 1) ? K_UP : K_NONE, 1'b1, 1'b0);
      checks += 2;
      if (respawning !== (i < RESPAWN)) begin errors++; $display("FAIL hit_len step%0d respawning got %b want %b", i, respawning, (i < RESPAWN)); end
      if (lives !== 3'd2) begin errors++; $display("FAIL hit_invuln step%0d lives got %0d want 2", i, lives); end
    end
    tick(K_UP, 1'b0, 1'b0);
    checks++;
    if (frog_row !== 4'd15) begin errors++; $display("FAIL held_through_hit row got %0d want 15", frog_row); end
    tick(K_NONE, 1'b0, 1'b0);
  endtask

  task automatic test_game_over();
    tick(K_NONE, 1'b1, 1'b0);
    for (int i = 0; i < RESPAWN; i++) tick(K_NONE, 1'b0, 1'b0);
    checks++;
    if (respawning !== 1'b0) begin errors++; $display("FAIL second_hit_end respawning got %b want 0", respawning); end
    tick(K_NONE, 1'b1, 1'b0);
    checks += 3;
    if (lives !== 3'd0) begin errors++; $display("FAIL last_life lives got %0d want 0", lives); end
    if (game_over !== 1'b1) begin errors++; $display("FAIL last_life game_over got %b want 1", game_over); end
    if (respawning !== 1'b0) begin errors++; $display("FAIL last_life respawning got %b want 0", respawning); end
    tick(K_UP, 1'b0, 1'b0);
    tick(K_NONE, 1'b0, 1'b0);
    tick(K_LEFT, 1'b1, 1'b0);
    tick(K_NONE, 1'b0, 1'b0);
    checks += 3;
    if (frog_row !== 4'd15 || frog_col !== 4'd7) begin errors++; $display("FAIL over_keys pos got %0d,%0d want 15,7", frog_row, frog_col); end
    if (lives !== 3'd0) begin errors++; $display("FAIL over_crash lives got %0d want 0", lives); end
    if (game_over !== 1'b1) begin errors++; $display("FAIL over_hold game_over got %b want 1", game_over); end
    tick(K_NONE, 1'b0, 1'b1);
    checks += 3;
    if (lives !== 3'd3) begin errors++; $display("FAIL restart lives got %0d want 3", lives); end
    if (score !== 8'd0) begin errors++; $display("FAIL restart score got %0d want 0", score); end
    if (game_over !== 1'b0) begin errors++; $display("FAIL restart game_over got %b want 0", game_over); end
    tick(K_UP, 1'b0, 1'b0);
    tick(K_NONE, 1'b0, 1'b0);
    checks++;
    if (frog_row !== 4'd14) begin errors++; $display("FAIL restart_play row got %0d want 14", frog_row); end
  endtask

  task automatic test_hold();
    int exp;
    for (int i = 0; i < 4; i++) begin tick(K_UP, 1'b0, 1'b0); tick(K_NONE, 1'b0, 1'b0); end
    checks++;
    if (frog_row !== 4'd10) begin errors++; $display("FAIL hold_setup row got %0d want 10", frog_row); end
    tick(K_DOWN, 1'b0, 1'b0);
    exp = 11;
    for (int k = 1; k <= 10; k++) begin
      tick(K_DOWN, 1'b0, 1'b0);
`ifdef KEY_REPEAT_EN
      exp = 11 + k / REPEAT;
`else
      exp = 11;
`endif
      checks++;
      if (frog_row !== exp[3:0]) begin errors++; $display("FAIL hold_down k%0d row got %0d want %0d", k, frog_row, exp); end
    end
    for (int k = 0; k < 6; k++) tick(K_NONE, 1'b0, 1'b0);
    checks++;
    if (frog_row !== exp[3:0]) begin errors++; $display("FAIL release row got %0d want %0d", frog_row, exp); end
  endtask

  task automatic test_random();
    logic [3:0] keys;
    logic       crash, st;
    do_reset();
    tick(K_NONE, 1'b0, 1'b1);
    keys = K_NONE;
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 99) < 25) keys[k] = ~keys[k];
      crash = ($urandom_range(0, 99) < 4);
      st    = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick(keys, crash, st);
      checks += 6;
      if (frog_row !== m_row[3:0]) begin errors++; $display("FAIL rand%0d row got %0d want %0d", n, frog_row, m_row); end
      if (frog_col !== m_col[3:0]) begin errors++; $display("FAIL rand%0d col got %0d want %0d", n, frog_col, m_col); end
      if (lives !== m_lives[2:0]) begin errors++; $display("FAIL rand%0d lives got %0d want %0d", n, lives, m_lives); end
      if (score !== m_score[7:0]) begin errors++; $display("FAIL rand%0d score got %0d want %0d", n, score, m_score); end
      if (game_over !== (m_mode == M_OVER)) begin errors++; $display("FAIL rand%0d game_over got %b want %b", n, game_over, (m_mode == M_OVER)); end
      if (respawning !== (m_mode == M_HIT)) begin errors++; $display("FAIL rand%0d respawning got %b want %b", n, respawning, (m_mode == M_HIT)); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    crash_in = 1'b0;
    {key_right, key_left, key_down, key_up} = K_NONE;
    test_reset();
    test_reset_mid_play();
    test_edge_moves();
    test_goal();
    test_crash();
    test_game_over();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
